// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, host-transmit FSM encoding and odd-parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Counter widths: cycle counters cover up to 2^20-1, the edge counter covers 11 edges.
    localparam int unsigned PS2_CNT_W  = 20;
    localparam int unsigned PS2_EDGE_W = 4;

    // Default cycle budgets at 50 MHz: 100 us inhibit, 20 ms device response window.
    localparam int unsigned PS2_INHIBIT_CYCLES_DEF = 5000;
    localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 1000000;

    // Host-to-device frame: 8 data + parity + stop + device acknowledge edge.
    localparam int unsigned PS2_FRAME_EDGES = 11;

    // Command bytes sent to the keyboard.
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    // Odd parity: the parity bit makes the total count of ones in data+parity odd.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer plus falling-edge pulse for one PS/2 line.
// Latency: line_sync lags the pin by 2 clk; fall is high in the first cycle line_sync reads 0.
// Backpressure: none; free-running sampler.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic line_sync,
    output logic fall
);

    logic meta;
    logic prev;

    // Two synchronizer stages plus one history flop; an idle PS/2 line rests high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            prev      <= 1'b1;
        end else begin
            meta      <= line;
            line_sync <= meta;
            prev      <= line_sync;
        end
    end

    assign fall = prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, RTS, 11-bit shift, ack check).
// Latency: pin falling edge to data_oe update 3 clk; done/error 1 clk after the synchronized condition.
// Backpressure: tx_ready only in IDLE (not its first cycle); tx_valid/tx_byte ignored while busy.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       data,
    output logic       ps2_clk_oe,
    output logic       data_oe,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [PS2_CNT_W-1:0]  CNT_ONE     = PS2_CNT_W'(1);
    localparam logic [PS2_CNT_W-1:0]  INH_LAST    = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0]  INH_START   = PS2_CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [PS2_CNT_W-1:0]  TMO_LAST    = PS2_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PS2_EDGE_W-1:0] EDGE_ONE    = PS2_EDGE_W'(1);
    localparam logic [PS2_EDGE_W-1:0] EDGE_PARITY = PS2_EDGE_W'(PS2_FRAME_EDGES - 2);

    ps2_tx_state_t         state, state_n;
    logic [PS2_CNT_W-1:0]  cnt, cnt_n;
    logic [PS2_EDGE_W-1:0] edge_cnt, edge_n;
    logic [9:0]            shreg, shreg_n;
    logic                  clk_oe_n, data_oe_n, ready_n, busy_n, done_n, err_n;
    logic                  clk_sync, clk_fall, data_sync, data_fall_unused;
    logic                  timeout;

    ps2_line_sync u_clk_sync (
        .clk       (clk),
        .reset     (reset),
        .line      (ps2_clk),
        .line_sync (clk_sync),
        .fall      (clk_fall)
    );

    // Data edges carry no meaning for the transmitter; only the level is sampled.
    ps2_line_sync u_data_sync (
        .clk       (clk),
        .reset     (reset),
        .line      (data),
        .line_sync (data_sync),
        .fall      (data_fall_unused)
    );

    // State, counters and every output are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            edge_cnt   <= '0;
            shreg      <= '0;
            ps2_clk_oe <= 1'b0;
            data_oe    <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            edge_cnt   <= edge_n;
            shreg      <= shreg_n;
            ps2_clk_oe <= clk_oe_n;
            data_oe    <= data_oe_n;
            tx_ready   <= ready_n;
            busy       <= busy_n;
            tx_done    <= done_n;
            tx_error   <= err_n;
        end
    end

    // Next-state and next-output logic; the timeout check wins over a same-cycle clock edge.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        edge_n    = edge_cnt;
        shreg_n   = shreg;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = data_oe;
        ready_n   = tx_ready;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        timeout   = (cnt == TMO_LAST);

        case (state)
            ST_IDLE: begin
                ready_n = 1'b1;
                cnt_n   = '0;
                if (tx_valid && tx_ready) begin
                    state_n   = ST_INHIBIT;
                    ready_n   = 1'b0;
                    clk_oe_n  = 1'b1;
                    data_oe_n = (INHIBIT_CYCLES == 1);
                    shreg_n   = {1'b1, ps2_odd_parity(tx_byte), tx_byte};
                end
            end
            ST_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_n   = ST_RELEASE;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                    if (INHIBIT_CYCLES >= 2 && cnt == INH_START) begin
                        data_oe_n = 1'b1;
                    end
                end
            end
            ST_RELEASE, ST_SHIFT, ST_ACK: begin
                if (timeout) begin
                    state_n   = ST_IDLE;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    ready_n   = 1'b0;
                    err_n     = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                    if (state == ST_RELEASE) begin
                        edge_n  = '0;
                        state_n = ST_SHIFT;
                    end else if (clk_fall && state == ST_SHIFT) begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = {1'b0, shreg[9:1]};
                        edge_n    = edge_cnt + EDGE_ONE;
                        if (edge_cnt == EDGE_PARITY) begin
                            state_n = ST_ACK;
                        end
                    end else if (clk_fall) begin
                        edge_n = edge_cnt + EDGE_ONE;
                        if (!data_sync) begin
                            state_n = ST_WAIT_IDLE;
                        end else begin
                            state_n   = ST_IDLE;
                            clk_oe_n  = 1'b0;
                            data_oe_n = 1'b0;
                            ready_n   = 1'b0;
                            err_n     = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_n = ST_IDLE;
                    ready_n = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                ready_n   = 1'b0;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a behavioural keyboard model on the open-drain lines.
// Latency: n/a.
// Backpressure: stimulus waits on tx_ready before each request.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 5000;
    localparam int TMO   = 1000;
    localparam int HALF  = 20;
    localparam int GUARD = 20000;

    localparam logic [1:0] K_ACK  = 2'd0;
    localparam logic [1:0] K_NACK = 2'd1;
    localparam logic [1:0] K_TMO  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, data, ps2_clk_oe, data_oe;
    logic [7:0] tx_byte;
    logic       tx_valid, tx_ready, busy, tx_done, tx_error;

    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic [1:0] dev_mode     = 2'd0;
    logic       dev_abort    = 1'b0;
    logic       dev_prev_oe  = 1'b0;
    int         dev_edges    = 0;

    exp_t       exp_q[$];
    logic [9:0] got_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         release_cyc = 0;
    int         inhibit_start_cyc = 0;
    int         done_cyc = -1;
    int         inh_cnt = 0;
    int         inh_data_cnt = 0;
    logic       prev_clk_oe = 1'b0;
    logic       err_follow = 1'b0;

    // Open-drain lines: either side pulling low wins, otherwise the pull-up holds them high.
    assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
    assign data    = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .data       (data),
        .ps2_clk_oe (ps2_clk_oe),
        .data_oe    (data_oe),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, GUARD);
    endtask

    // Reference frame as the device should see it: LSB-first data, odd parity, stop=1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    function automatic exp_t mk_exp(input logic [1:0] kind, input logic [7:0] b);
        exp_t e;
        e.kind = kind;
        e.b    = b;
        return e;
    endfunction

    task automatic dev_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (reset) begin
                dev_abort = 1'b1;
                return;
            end
        end
    endtask

    // Keyboard side of one host-to-device frame: clocks, reads bits on rising edges, acks.
    task automatic dev_frame();
        logic [9:0] cap;
        cap       = '0;
        dev_abort = 1'b0;
        dev_edges = 0;
        if (dev_mode == K_TMO) return;
        dev_wait(10);
        for (int k = 1; k <= PS2_FRAME_EDGES; k++) begin
            if (dev_abort) break;
            dev_clk_low = 1'b1;
            dev_edges   = k;
            dev_wait(HALF);
            if (dev_abort) break;
            dev_clk_low = 1'b0;
            if (k <= 10) cap[k-1] = data;
            if (k == 10) begin
                got_q.push_back(cap);
                if (dev_mode == K_ACK) dev_data_low = 1'b1;
            end
            if (k == 11) dev_data_low = 1'b0;
            dev_wait(HALF);
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    initial begin : device
        forever begin
            @(negedge clk);
            if (!reset && dev_prev_oe && !ps2_clk_oe && !data) dev_frame();
            dev_prev_oe = ps2_clk_oe;
        end
    end

    // Line monitor: inhibit length and start-bit placement around clock release.
    initial begin : line_mon
        forever begin
            @(negedge clk);
            if (reset) begin
                inh_cnt      = 0;
                inh_data_cnt = 0;
            end else if (ps2_clk_oe) begin
                if (!prev_clk_oe) inhibit_start_cyc = cyc;
                inh_cnt++;
                if (data_oe) inh_data_cnt++;
            end else if (prev_clk_oe) begin
                release_cyc = cyc;
                check("inhibit_len", inh_cnt, INH);
                check("start_bit_in_inhibit", inh_data_cnt, 1);
                check("start_bit_at_release", data_oe, 1);
                inh_cnt      = 0;
                inh_data_cnt = 0;
            end
            prev_clk_oe = ps2_clk_oe;
        end
    end

    // Scoreboard: every done/error pulse must match the oldest outstanding request.
    initial begin : scoreboard
        exp_t       e;
        logic [9:0] g;
        forever begin
            @(negedge clk);
            if (err_follow) begin
                check("oe_released_after_error", {30'd0, ps2_clk_oe, data_oe}, 0);
                err_follow = 1'b0;
            end
            if (tx_done || tx_error) begin
                check("done_error_exclusive", tx_done & tx_error, 0);
                if (tx_done) done_cyc = cyc;
                if (tx_error) err_follow = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: got done=%0b error=%0b, required no pulse",
                             tx_done, tx_error);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome_done", tx_done, e.kind == K_ACK);
                    check("outcome_error", tx_error, e.kind != K_ACK);
                    if (e.kind == K_TMO) begin
                        check("timeout_latency", cyc - release_cyc, TMO);
                        check("idle_after_timeout", busy, 0);
                    end else if (got_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame_missing: got no frame, required %0h", model_frame(e.b));
                    end else begin
                        g = got_q.pop_front();
                        check("frame_bits", g, model_frame(e.b));
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!tx_ready && g < GUARD) begin
            @(negedge clk);
            g++;
        end
        if (!tx_ready) fail_now("ready_wait");
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < GUARD) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            fail_now("response_wait");
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] kind);
        wait_ready();
        exp_q.push_back(mk_exp(kind, b));
        tx_byte  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_byte  = 8'($urandom);
        check("busy_after_accept", busy, 1);
        wait_drain();
    endtask

    initial begin : stim
        int         g;
        int         old_done;
        logic [7:0] b1, b2;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        #12;
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_error", tx_error, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        send(PS2_CMD_SET_LEDS, K_ACK);
        send(8'h01, K_ACK);
        repeat (2) @(negedge clk);
        check("ready_between_frames", tx_ready, 1);
        send(PS2_CMD_RESET, K_ACK);

        dev_mode = K_NACK;
        send(8'($urandom), K_NACK);
        dev_mode = K_TMO;
        send(8'($urandom), K_TMO);
        dev_mode = K_ACK;

        // Reset in the middle of the shift phase, after edge 4 has driven a 0 bit.
        wait_ready();
        tx_byte  = 8'($urandom) & 8'hF7;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        g = 0;
        while (dev_edges != 4 && g < GUARD) begin
            @(negedge clk);
            g++;
        end
        if (dev_edges != 4) fail_now("edge4_wait");
        repeat (4) @(negedge clk);
        check("data_oe_before_reset", data_oe, 1);
        #2 reset = 1'b1;
        #1;
        check("reset_clk_oe_async", ps2_clk_oe, 0);
        check("reset_data_oe_async", data_oe, 0);
        check("reset_ready_async", tx_ready, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);
        send(PS2_CMD_ENABLE, K_ACK);

        // tx_valid held across a completed frame: the next inhibit starts 2 cycles after done.
        wait_ready();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        exp_q.push_back(mk_exp(K_ACK, b1));
        exp_q.push_back(mk_exp(K_ACK, b2));
        old_done = done_cyc;
        tx_byte  = b1;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_byte = b2;
        g = 0;
        while (done_cyc == old_done && g < GUARD) begin
            @(negedge clk);
            g++;
        end
        if (done_cyc == old_done) fail_now("first_done_wait");
        g = 0;
        while (inhibit_start_cyc <= done_cyc && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("back_to_back_gap", inhibit_start_cyc - done_cyc, 2);
        tx_valid = 1'b0;
        wait_drain();

        repeat (2) send(8'($urandom_range(0, 255)), K_ACK);

        repeat (5) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("frame_queue_empty", got_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same two open-drain lines the keyboard receiver listens on. It performs the inhibit / request-to-send sequence, shifts out 8 data bits, odd parity and stop, then checks the device's line-level acknowledge. It sits beside the keyboard receiver and shares its `ps2_clk` and `data` pins. Each pin is driven through a pad that pulls low when its `_oe` is 1.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: clk cycles `ps2_clk` is held low before the start bit (100 µs at 50 MHz); range 1 to 2^20−1.
- `TIMEOUT_CYCLES`, default 1000000: maximum clk cycles from clock release to the acknowledge sample (20 ms at 50 MHz); range 1 to 2^20−1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin level (asynchronous).
- `data`  in  1  raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull clock line low.
- `data_oe`  out  1  1 = pull data line low.
- `tx_byte`  in  8  command byte to send.
- `tx_valid`  in  1  request to send.
- `tx_ready`  out  1  1 only in IDLE; a byte is accepted when `tx_valid & tx_ready`.
- `busy`  out  1  1 in every state except IDLE; the receiver ignores line traffic while this is set.
- `tx_done`  out  1  one-cycle pulse on successful acknowledge.
- `tx_error`  out  1  one-cycle pulse on NACK or timeout.

## Operation
- Reset values: `ps2_clk_oe=0`, `data_oe=0`, `tx_ready=1`, `busy=0`, `tx_done=0`, `tx_error=0`, state IDLE, all counters 0.
- Reset takes effect asynchronously and can arrive in any state. Both lines are released at once and the frame is abandoned without a `tx_done` or `tx_error` pulse.
- Frame latched on accept: `{stop=1, parity=~^tx_byte, tx_byte[7:0]}`, shifted LSB first. `data_oe` is the inverse of the current bit.
- The two line inputs pass through 2-flop synchronizers. The FSM acts on a falling edge of the synchronized clock (previous sample 1, current sample 0).
- States and transitions:
  - IDLE: on accept go to INHIBIT and assert `ps2_clk_oe`. A request is accepted even while a device frame is in progress; inhibit legally aborts that frame.
  - INHIBIT: count `INHIBIT_CYCLES`. On the last count cycle assert `data_oe` (start bit), then go to RELEASE.
  - RELEASE: deassert `ps2_clk_oe` and keep `data_oe=1`. Clear the edge counter, start the timeout counter, go to SHIFT.
  - SHIFT: falling edges k=1..8 drive data bit k−1; edge 9 drives parity; edge 10 drives stop (`data_oe=0`). After edge 10 go to ACK.
  - ACK: on falling edge 11, sample synchronized `data`. Value 0 goes to WAIT_IDLE; value 1 pulses `tx_error` and returns to IDLE.
  - WAIT_IDLE: once synchronized `ps2_clk` and `data` are both 1, pulse `tx_done` and return to IDLE.
- Timeout: the counter runs through RELEASE, SHIFT and ACK. On reaching `TIMEOUT_CYCLES` it pulses `tx_error`, releases both lines and returns to IDLE. Timeout takes priority over a falling edge in the same cycle.
- `tx_done` and `tx_error` are mutually exclusive.
- A new `tx_valid` is not accepted before the cycle after the return to IDLE. Inputs are ignored while `busy=1`.
- The device's 0xFA response byte is handled by the receiver, not by this block.

## Timing
- Accept at cycle N. `ps2_clk_oe=1` from N+1 through N+`INHIBIT_CYCLES`.
- `data_oe` rises at cycle N+`INHIBIT_CYCLES`. `ps2_clk_oe` falls at cycle N+`INHIBIT_CYCLES`+1.
- From a falling edge on the pin to the `data_oe` update: 3 clk cycles (2 synchronizer stages + 1 registered edge/FSM stage). This is well inside the ≥5 µs clock-low phase of the device.
- `tx_done`/`tx_error` are registered. They assert 1 cycle after the deciding condition is seen on the synchronized signals.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ps2_pkg`:
  - FSM state encoding (IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE).
  - Odd-parity function.
  - Default cycle constants.
  - Frame-length constant of 11 clock edges.
  - Command byte constants (0xED, 0xF4, 0xFF), shared with the receiver's scan-code constants.
- Sub-module `ps2_line_sync`:
  - 2-flop synchronizer plus falling-edge pulse for one line; instantiated twice here.
  - Reusable by the receiver in place of its ad-hoc edge tracking.
- Counters are 20 bits wide; edge counter is 4 bits.

## Test plan
- Send 0xED with a device model that acks. Required: inhibit lasts exactly 5000 cycles; bits sampled on rising edges read 1,0,1,1,0,1,1,1; parity 1; stop line released; `tx_done` pulses once; `tx_error` stays 0.
- Send 0x01, then 0xFF. Required: parity bit 0, then 1; `tx_ready` returns to 1 between the two frames.
- Device drives data high at edge 11 (NACK). Required: `tx_error` pulses; both `_oe` are 0 the following cycle; no `tx_done`.
- Device never clocks, with `TIMEOUT_CYCLES`=1000. Required: `tx_error` pulses 1000 cycles after clock release; state returns to IDLE.
- `reset` asserted mid-SHIFT after edge 4. Required: both `_oe` go to 0 without waiting for `clk`; no `tx_done`/`tx_error` pulse; `tx_ready`=1 after release; the next 0xF4 frame completes normally.
- `tx_valid` held high through a completed frame. Required: the second frame's inhibit starts exactly 2 cycles after the `tx_done` pulse.
